// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the fetch-queue entry type.
// Used by fetch_queue and its storage sub-module fq_fifo.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [ADDR_W-1:0] PC_INC = 16'd2;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps silently modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// Circular FIFO of fetch entries: pointers, occupancy count and entry array.
// push/pop qualification is done by the owner; flush clears all bookkeeping.
module fq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_entry,
  output logic         full,
  output logic         head_valid,
  output fetch_entry_t head_entry
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  fetch_entry_t mem_q [DEPTH];

  logic wr_en;

  assign wr_en      = push & ~flush;
  assign full       = (count_q == DEPTH_CNT);
  assign head_valid = (count_q != '0);
  assign head_entry = mem_q[rptr_q];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: flops use non-blocking <= so every register samples the values
    // from before the edge, independent of statement order.
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: the entry array is deliberately not reset; count_q gates every
  // read, so stale contents are never observable and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wr_entry;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetch_pc sequencing, redirect flush, head outputs.
// Define FETCH_QUEUE_PERF_EN to add saturating flush_count / stall_count ports.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stall,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [15:0]        flush_count,
  output logic [15:0]        stall_count
`endif
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

  logic         push;
  logic         pop;
  logic         full;
  logic         head_valid;
  fetch_entry_t head_entry;
  fetch_entry_t wr_entry;

  // Redirect wins over both ends; a full queue still accepts when the head leaves.
  assign pop      = head_valid & ~stall & ~redirect;
  assign push     = ~redirect & (~full | pop);
  assign wr_entry = '{pc: fetch_pc_q, instr: im_data};
  assign im_addr  = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)  fetch_pc_d = redirect_pc;
    else if (push) fetch_pc_d = next_pc(fetch_pc_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_pc_q <= RESET_PC;
    else     fetch_pc_q <= fetch_pc_d;
  end

  fq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push),
    .pop        (pop),
    .wr_entry   (wr_entry),
    .full       (full),
    .head_valid (head_valid),
    .head_entry (head_entry)
  );

  // Head outputs come only from stored entries, never from im_data.
  assign instr_valid = head_valid;
  assign instr_out   = head_valid ? head_entry.instr : '0;
  assign instr_pc    = head_valid ? head_entry.pc    : '0;

`ifdef FETCH_QUEUE_PERF_EN
  logic [15:0] flush_count_q, flush_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    flush_count_d = flush_count_q;
    stall_count_d = stall_count_q;
    if (redirect && (flush_count_q != 16'hFFFF))
      flush_count_d = flush_count_q + 16'd1;
    if (head_valid && stall && (stall_count_q != 16'hFFFF))
      stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      flush_count_q <= flush_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign flush_count = flush_count_q;
  assign stall_count = stall_count_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random
// redirect/stall/reset traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic [15:0] im_addr;
  logic [15:0] im_data;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
`ifdef FETCH_QUEUE_PERF_EN
  logic [15:0] flush_count;
  logic [15:0] stall_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] imem [65536];

  always #5 clk = ~clk;

  assign im_data = imem[im_addr];

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .im_addr     (im_addr),
    .im_data     (im_data),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .flush_count (flush_count),
    .stall_count (stall_count)
`endif
  );

  // ---------------- reference model: an ordered list of {pc, instr} ----------------
  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } m_entry_t;

  m_entry_t    mq[$];
  logic [15:0] m_pc;
  int          m_flush;
  int          m_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = RESET_PC;
    m_flush = 0;
    m_stall = 0;
  endtask

  // Advance the model across one rising edge given the inputs held before it.
  task automatic model_edge(input logic rd, input logic [15:0] rpc, input logic st);
    m_entry_t e;
    bit       has_head;
    has_head = (mq.size() != 0);
    if (rd && m_flush < 65535) m_flush++;
    if (has_head && st && m_stall < 65535) m_stall++;
    if (rd) begin
      mq.delete();
      m_pc = rpc;
    end else begin
      if (has_head && !st) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        e.pc    = m_pc;
        e.instr = imem[m_pc];
        mq.push_back(e);
        m_pc = m_pc + 16'd2;
      end
    end
  endtask

  task automatic check_model();
    bit has_head;
    has_head = (mq.size() != 0);
    check("valid", {31'd0, instr_valid}, {31'd0, has_head});
    check("instr_out", {16'd0, instr_out}, has_head ? {16'd0, mq[0].instr} : 32'd0);
    check("instr_pc", {16'd0, instr_pc}, has_head ? {16'd0, mq[0].pc} : 32'd0);
    check("im_addr", {16'd0, im_addr}, {16'd0, m_pc});
`ifdef FETCH_QUEUE_PERF_EN
    check("flush_count", {16'd0, flush_count}, m_flush);
    check("stall_count", {16'd0, stall_count}, m_stall);
`endif
  endtask

  // Called at a falling edge: apply inputs, compare current state, cross one rising edge.
  task automatic step(input logic rd, input logic [15:0] rpc, input logic st);
    redirect    = rd;
    redirect_pc = rpc;
    stall       = st;
    #1;
    check_model();
    model_edge(rd, rpc, st);
    @(posedge clk);
    @(negedge clk);
  endtask

  // One-cycle reset pulse starting at a falling edge; outputs must clear at once.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr_out", {16'd0, instr_out}, 32'd0);
    check("rst_instr_pc", {16'd0, instr_pc}, 32'd0);
    check("rst_im_addr", {16'd0, im_addr}, {16'd0, RESET_PC});
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) imem[i] = 16'($urandom);
    imem[0] = 16'h1234;

    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    stall       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_valid", {31'd0, instr_valid}, 32'd0);
    check("reset_instr_out", {16'd0, instr_out}, 32'd0);
    check("reset_im_addr", {16'd0, im_addr}, {16'd0, RESET_PC});
    rst = 1'b0;

    // First fetch one cycle after reset release.
    step(1'b0, 16'h0000, 1'b0);
    check("first_valid", {31'd0, instr_valid}, 32'd1);
    check("first_instr", {16'd0, instr_out}, 32'h1234);
    check("first_pc", {16'd0, instr_pc}, 32'h0000);

    // Stall holds the head while the queue fills to DEPTH.
    repeat (8) step(1'b0, 16'h0000, 1'b1);
    check("stall_im_addr", {16'd0, im_addr}, 32'h0008);
    check("stall_head_pc", {16'd0, instr_pc}, 32'h0000);

    // Released from full: one pop and one push per cycle, no gaps.
    for (int i = 0; i < 5; i++) begin
      redirect = 1'b0;
      stall    = 1'b0;
      #1;
      check("flow_valid", {31'd0, instr_valid}, 32'd1);
      check("flow_pc", {16'd0, instr_pc}, i * 2);
      step(1'b0, 16'h0000, 1'b0);
    end

    // Build exactly three queued entries, then redirect.
    step(1'b1, 16'h0100, 1'b0);
    repeat (3) step(1'b0, 16'h0000, 1'b1);
    check("pre_redir_im_addr", {16'd0, im_addr}, 32'h0106);
    step(1'b1, 16'h0040, 1'($urandom_range(0, 1)));
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_im_addr", {16'd0, im_addr}, 32'h0040);
    step(1'b0, 16'h0000, 1'b0);
    check("redir_head_valid", {31'd0, instr_valid}, 32'd1);
    check("redir_head_pc", {16'd0, instr_pc}, 32'h0040);

    // PC wrap at the top of the address space.
    step(1'b1, 16'hFFFE, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    check("wrap_pc0", {16'd0, instr_pc}, 32'hFFFE);
    step(1'b0, 16'h0000, 1'b0);
    check("wrap_pc1", {16'd0, instr_pc}, 32'h0000);
    step(1'b0, 16'h0000, 1'b0);
    check("wrap_pc2", {16'd0, instr_pc}, 32'h0002);

    // Fill, then reset mid-stream; refetch restarts at RESET_PC.
    repeat (6) step(1'b0, 16'h0000, 1'b1);
    pulse_reset();
    step(1'b0, 16'h0000, 1'b0);
    check("refetch_valid", {31'd0, instr_valid}, 32'd1);
    check("refetch_pc", {16'd0, instr_pc}, {16'd0, RESET_PC});
    check("refetch_instr", {16'd0, instr_out}, 32'h1234);

    // Three redirects after reset.
    repeat (3) step(1'b1, 16'h0200, 1'b0);
`ifdef FETCH_QUEUE_PERF_EN
    check("flush_count_3", {16'd0, flush_count}, 32'd3);
`endif
    check("post_redirects_valid", {31'd0, instr_valid}, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        logic        rd;
        logic        st;
        logic [15:0] rpc;
        rd  = ($urandom_range(0, 9) == 0);
        st  = ($urandom_range(0, 2) == 0);
        rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFA : (16'($urandom) & 16'hFFFE);
        step(rd, rpc, st);
      end
    end
    #1;
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 16'h0000, fetch address loaded at reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 redirect  input  1  taken branch/jump from decode; flushes queue.
REQ-006 redirect_pc  input  16  new fetch address, sampled when redirect=1.
REQ-007 stall  input  1  decode bubble or hazard hold; head entry not consumed.
REQ-008 im_addr  output  16  instruction memory address; equals fetch_pc.
REQ-009 im_data  input  16  instruction word returned combinationally for im_addr.
REQ-010 instr_valid  output  1  head entry present.
REQ-011 instr_out  output  16  head instruction word.
REQ-012 instr_pc  output  16  address of the head instruction, for branch/jump offset adders.

Function
REQ-013 The block SHALL hold fetch_pc, a DEPTH-entry circular FIFO of {pc, instr}, read/write pointers and an occupancy count of width clog2(DEPTH)+1.
REQ-014 pop SHALL equal instr_valid & ~stall & ~redirect.
REQ-015 push SHALL equal ~redirect & (count<DEPTH | pop); on push, entry {fetch_pc, im_data} is written and fetch_pc advances by 2, modulo 2^16.
REQ-016 Simultaneous push and pop on a full queue SHALL leave count unchanged and lose no entry.
REQ-017 Pop on empty SHALL be impossible; push on full without pop SHALL be blocked, and fetch_pc SHALL hold.
REQ-018 redirect SHALL take priority: next cycle count=0, both pointers=0, fetch_pc=redirect_pc, instr_valid=0, and any same-cycle push or pop is discarded.
REQ-019 Latency: after reset release or redirect, instr_valid SHALL rise exactly one cycle later, with the instruction at the new fetch_pc.
REQ-020 instr_valid, instr_out and instr_pc SHALL be driven from the head entry with no combinational path from im_data; instr_out and instr_pc SHALL read 16'h0000 when instr_valid=0.
REQ-021 With stall held, head outputs SHALL remain stable, and filling SHALL continue until count=DEPTH.
REQ-022 fetch_pc wrap 16'hFFFE -> 16'h0000 SHALL be silent; no error flag.

Reset
REQ-023 While rst=1, asynchronously: fetch_pc=RESET_PC, pointers=0, count=0, instr_valid=0, instr_out=0, instr_pc=0, all optional counters=0.
REQ-024 Reset asserted mid-operation SHALL discard all queued entries, with no partial push completing.

Configuration
REQ-025 When macro FETCH_QUEUE_PERF_EN is defined, the block SHALL add output flush_count (16 bits, incremented on each cycle with redirect=1, saturating at 16'hFFFF) and output stall_count (16 bits, incremented each cycle with instr_valid & stall, saturating); when the macro is undefined, both ports and their logic SHALL be absent.

Structure
REQ-026 Constants for instruction width (16), address width (16) and PC increment (2) SHALL live in shared package cpu_pkg, along with the fetch-entry typedef {pc, instr}.
REQ-027 Storage SHALL be a sub-module fq_fifo (pointers, count, entry array); fetch_pc and redirect logic SHALL reside in fetch_queue.

Verification
REQ-028 Reset release, stall=0, IM[0]=16'h1234 -> next cycle instr_valid=1, instr_out=16'h1234, instr_pc=16'h0000.
REQ-029 stall=1 held for 8 cycles, DEPTH=4 -> count saturates at 4, im_addr holds at 16'h0008, and head stays instr_pc=16'h0000.
REQ-030 Full queue, stall released -> one pop and one push each cycle; instr_pc sequence 0,2,4,6,8 with no gap.
REQ-031 redirect=1 with redirect_pc=16'h0040 while 3 entries are queued -> next cycle instr_valid=0; the following cycle instr_pc=16'h0040; old entries are never presented.
REQ-032 redirect_pc=16'hFFFE, no stall -> instr_pc sequence FFFE, 0000, 0002.
REQ-033 rst asserted for one cycle mid-stream with the queue full -> all outputs are 0 immediately, and refetch starts at RESET_PC; with FETCH_QUEUE_PERF_EN defined, 3 redirects -> flush_count=3.
